// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count_seq start/done sequencer.
// Holds the FSM state encoding used by count_seq_top and a small decode helper.
// No ports; imported by count_seq_top and count_seq_dp.
package count_seq_pkg;

  localparam int STATE_W = 2;

  // Encoding is fixed so state values can be read directly on a waveform.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The sequencer reports busy in every state except IDLE.
  function automatic logic is_active(input state_t s);
    return (s != IDLE);
  endfunction

  // RUN exits to DONE when done is a registered (Moore) decode and straight
  // back to IDLE when done is decoded combinationally from RUN & tc.
  function automatic state_t run_exit_state(input int mealy_done);
    return (mealy_done != 0) ? IDLE : DONE;
  endfunction

endpackage

// File: rtl/count_seq_dp.sv
// Counter datapath: WIDTH-bit clear/increment counter plus latched run length.
// Ports: clock, rst (sync, active-high); clr/inc/load controls; len in;
//        count out (current value), tc out (count equals latched length).
module count_seq_dp
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] len_q;

  // clr has priority over inc; the controller never raises both, but a
  // clear must always leave the counter at zero.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
      len_q   <= '0;
    end else begin
      if (clr) begin
        count_q <= '0;
      end else if (inc) begin
        count_q <= count_q + WIDTH'(1);
      end
      if (load) begin
        len_q <= len;
      end
    end
  end

  // Exact equality: the run stops on the latched length, so the counter
  // can reach 2**WIDTH-1 but is never asked to step past it.
  assign tc    = (count_q == len_q);
  assign count = count_q;

endmodule

// File: rtl/count_seq_top.sv
// Start/done sequencer: FSM controller driving a clear/increment counter datapath.
// Ports: clock, rst (sync, active-high); start, len, abort in;
//        busy (not IDLE), done (one-cycle completion pulse), count (counter value) out.
module count_seq_top
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MEALY_DONE = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t state;
  state_t state_d;
  state_t run_exit;
  logic   clr;
  logic   inc;
  logic   load;
  logic   tc;
  logic   busy_q;

  // Next-state and datapath control. abort is only honoured once a run is
  // in flight, and it suppresses clr/inc so the count freezes where it is.
  always_comb begin
    state_d = state;
    clr     = 1'b0;
    inc     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = run_exit;
        end else begin
          inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy is registered alongside the state so it is glitch-free.
  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      busy_q <= is_active(state_d);
    end
  end

  assign busy = busy_q;

  // Done timing option: Mealy asserts done in the RUN cycle that sees tc
  // (gated by abort) and returns straight to IDLE; Moore spends one cycle
  // in DONE and asserts done from that state.
  generate
    if (MEALY_DONE != 0) begin : g_mealy
      assign run_exit = run_exit_state(1);
      assign done     = (state == RUN) & tc & ~abort;
    end else begin : g_moore
      assign run_exit = run_exit_state(0);
      assign done     = (state == DONE);
    end
  endgenerate

  count_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock(clock),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .load (load),
    .len  (len),
    .count(count),
    .tc   (tc)
  );

endmodule

// File: tb/tb_count_seq_top.sv
module tb_count_seq_top;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] len   = 8'd0;

  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [3:0] cnt2;
  logic [3:0] cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // 0: WIDTH 8 Moore, 1: WIDTH 8 Mealy, 2: WIDTH 4 Moore, 3: WIDTH 4 Mealy
  count_seq_top #(.WIDTH(8), .MEALY_DONE(0)) u_moore8 (
    .clock(clock), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy_v[0]), .done(done_v[0]), .count(cnt0));
  count_seq_top #(.WIDTH(8), .MEALY_DONE(1)) u_mealy8 (
    .clock(clock), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy_v[1]), .done(done_v[1]), .count(cnt1));
  count_seq_top #(.WIDTH(4), .MEALY_DONE(0)) u_moore4 (
    .clock(clock), .rst(rst), .start(start), .len(len[3:0]), .abort(abort),
    .busy(busy_v[2]), .done(done_v[2]), .count(cnt2));
  count_seq_top #(.WIDTH(4), .MEALY_DONE(1)) u_mealy4 (
    .clock(clock), .rst(rst), .start(start), .len(len[3:0]), .abort(abort),
    .busy(busy_v[3]), .done(done_v[3]), .count(cnt3));

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0: return {24'd0, cnt0};
      1: return {24'd0, cnt1};
      2: return {28'd0, cnt2};
      default: return {28'd0, cnt3};
    endcase
  endfunction

  function automatic bit is_mealy(input int i);
    return (i % 2) == 1;
  endfunction

  function automatic int len_mask(input int i);
    return (i < 2) ? 255 : 15;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: a run is described by the cycles elapsed since its
  // start was accepted (k=0 is the start-sample cycle). Cycle 1 is the clear
  // cycle, count(k)=k-2 from cycle 2 until it reaches L, done lands at
  // k=L+2 (Mealy) or k=L+3 (Moore), and the run is over after that cycle.
  bit known = 1'b0;
  bit act_m[4];
  int k_m[4];
  int l_m[4];
  int cnt_m[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      act_m[i] = 1'b0; k_m[i] = 0; l_m[i] = 0; cnt_m[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        int  last_k;
        bit  exp_done;
        last_k = is_mealy(i) ? l_m[i] + 2 : l_m[i] + 3;
        if (known) begin
          exp_done = act_m[i] && (k_m[i] == last_k) && (!is_mealy(i) || !abort);
          chk($sformatf("model_busy[%0d]", i), {31'd0, busy_v[i]}, {31'd0, act_m[i]});
          chk($sformatf("model_done[%0d]", i), {31'd0, done_v[i]}, {31'd0, exp_done});
          chk($sformatf("model_count[%0d]", i), get_cnt(i), cnt_m[i]);
        end
        if (rst) begin
          act_m[i] = 1'b0; cnt_m[i] = 0; l_m[i] = 0;
        end else if (!act_m[i]) begin
          if (start) begin
            act_m[i] = 1'b1; k_m[i] = 1; l_m[i] = int'(len) & len_mask(i);
          end
        end else if (abort || k_m[i] == last_k) begin
          act_m[i] = 1'b0;
        end else begin
          k_m[i]++;
          if (k_m[i] >= 2) cnt_m[i] = (k_m[i] - 2 > l_m[i]) ? l_m[i] : k_m[i] - 2;
        end
      end
      if (rst) known = 1'b1;
    end
  end

  // Per-cycle snapshots of directed scenarios for literal checks.
  logic        sbusy[4][64];
  logic        sdone[4][64];
  logic [31:0] scnt[4][64];

  task automatic cyc(input logic s, input logic [7:0] l, input logic a, input logic r);
    @(posedge clock);
    #1;
    start = s; len = l; abort = a; rst = r;
    @(negedge clock);
  endtask

  task automatic run_case(input int mode, input int n);
    for (int kk = 0; kk < n; kk++) begin
      logic       s;
      logic [7:0] l;
      logic       a;
      logic       r;
      s = 1'b0; l = 8'd0; a = 1'b0; r = 1'b0;
      case (mode)
        0: begin s = (kk == 0); l = (kk == 0) ? 8'd3 : 8'(kk); end
        1: begin s = (kk == 0); l = 8'd0; end
        2: begin s = (kk == 0); l = 8'd5; a = (kk == 4); end
        3: begin
          if (kk <= 1)      begin s = (kk == 0); l = 8'd2; end
          else if (kk <= 6) begin s = (kk != 3); l = 8'd4; end
          else if (kk <= 12) begin s = (kk <= 10) && (kk % 2 == 1); l = 8'd9; end
        end
        4: begin s = (kk == 0); l = 8'd15; end
        default: begin s = (kk == 0); l = 8'd12; r = (kk == 9); end
      endcase
      cyc(s, l, a, r);
      for (int i = 0; i < 4; i++) begin
        sbusy[i][kk] = busy_v[i];
        sdone[i][kk] = done_v[i];
        scnt[i][kk]  = get_cnt(i);
      end
    end
  endtask

  function automatic int first_done(input int i, input int from, input int n);
    for (int kk = from; kk < n; kk++) if (sdone[i][kk] === 1'b1) return kk;
    return -1;
  endfunction

  function automatic int npulse(input int i, input int n);
    int c = 0;
    for (int kk = 0; kk < n; kk++) if (sdone[i][kk] === 1'b1) c++;
    return c;
  endfunction

  function automatic int idx(input int v);
    return (v < 0 || v > 62) ? 0 : v;
  endfunction

  initial begin
    int fd;
    int sd;
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_busy[%0d]", i), {31'd0, busy_v[i]}, 0);
      chk($sformatf("reset_done[%0d]", i), {31'd0, done_v[i]}, 0);
      chk($sformatf("reset_count[%0d]", i), get_cnt(i), 0);
    end

    // len=3 single run
    run_case(0, 12);
    for (int i = 0; i < 4; i++) begin
      fd = first_done(i, 0, 12);
      chk($sformatf("len3_done_cycle[%0d]", i), fd, is_mealy(i) ? 5 : 6);
      chk($sformatf("len3_pulses[%0d]", i), npulse(i, 12), 1);
      chk($sformatf("len3_count_at_done[%0d]", i), scnt[i][idx(fd)], 3);
      chk($sformatf("len3_count_k2[%0d]", i), scnt[i][2], 0);
      chk($sformatf("len3_count_k4[%0d]", i), scnt[i][4], 2);
      chk($sformatf("len3_busy_after[%0d]", i), {31'd0, sbusy[i][idx(fd + 1)]}, 0);
    end

    // len=0
    run_case(1, 8);
    for (int i = 0; i < 4; i++) begin
      fd = first_done(i, 0, 8);
      chk($sformatf("len0_done_cycle[%0d]", i), fd, is_mealy(i) ? 2 : 3);
      chk($sformatf("len0_count_at_done[%0d]", i), scnt[i][idx(fd)], 0);
      chk($sformatf("len0_pulses[%0d]", i), npulse(i, 8), 1);
    end

    // len=5 aborted at count=2
    run_case(2, 12);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_pulses[%0d]", i), npulse(i, 12), 0);
      chk($sformatf("abort_busy_k4[%0d]", i), {31'd0, sbusy[i][4]}, 1);
      chk($sformatf("abort_busy_k5[%0d]", i), {31'd0, sbusy[i][5]}, 0);
      chk($sformatf("abort_count_hold[%0d]", i), scnt[i][8], 2);
    end

    // back-to-back runs, len 2 then 4, start/len toggled mid-run
    run_case(3, 20);
    for (int i = 0; i < 4; i++) begin
      fd = first_done(i, 0, 20);
      sd = first_done(i, fd + 1, 20);
      chk($sformatf("b2b_first_done[%0d]", i), fd, is_mealy(i) ? 4 : 5);
      chk($sformatf("b2b_second_done[%0d]", i), sd, is_mealy(i) ? 11 : 13);
      chk($sformatf("b2b_pulses[%0d]", i), npulse(i, 20), 2);
      chk($sformatf("b2b_count_first[%0d]", i), scnt[i][idx(fd)], 2);
      chk($sformatf("b2b_count_second[%0d]", i), scnt[i][idx(sd)], 4);
    end

    // len=15: full range of the 4-bit counter
    run_case(4, 24);
    for (int i = 0; i < 4; i++) begin
      fd = first_done(i, 0, 24);
      chk($sformatf("len15_done_cycle[%0d]", i), fd, is_mealy(i) ? 17 : 18);
      chk($sformatf("len15_count_at_done[%0d]", i), scnt[i][idx(fd)], 15);
      chk($sformatf("len15_pulses[%0d]", i), npulse(i, 24), 1);
      chk($sformatf("len15_count_hold[%0d]", i), scnt[i][23], 15);
    end

    // reset mid-run at count=7
    run_case(5, 40);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_count_k9[%0d]", i), scnt[i][9], 7);
      chk($sformatf("rst_busy_k10[%0d]", i), {31'd0, sbusy[i][10]}, 0);
      chk($sformatf("rst_count_k10[%0d]", i), scnt[i][10], 0);
      chk($sformatf("rst_done_k10[%0d]", i), {31'd0, sdone[i][10]}, 0);
      chk($sformatf("rst_pulses[%0d]", i), npulse(i, 40), 0);
    end

    // randomized traffic, checked by the model process
    for (int c = 0; c < 3000; c++) begin
      logic       s;
      logic [7:0] l;
      logic       a;
      logic       r;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cyc(s, l, a, r);
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 8'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
